// File: rtl/regression_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regression_predictor_pkg                                  |
// | Purpose  : Shared fixed-point definitions for the regression         |
// |            predictor: default width/fraction, saturation limits and  |
// |            the signed fixed-point sample/coefficient type.           |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package regression_predictor_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_FRAC  = 10;

  // Q(DEF_WIDTH-DEF_FRAC).DEF_FRAC value, two's complement.
  typedef logic signed [DEF_WIDTH-1:0] fxp_t;

  localparam fxp_t SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam fxp_t SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/regression_predictor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regression_predictor_if                                   |
// | Purpose  : Bundles the coefficient load, x-sample input stream,      |
// |            y-prediction output stream and status of the predictor.   |
// | Ports    : master - drives ld_coef, b_1_in, b_0_in, x_valid, x_in,   |
// |                     y_ready; observes the rest                       |
// |            slave  - the predictor side (opposite directions)         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface regression_predictor_if
  import regression_predictor_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_SAMPLES = 150
);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  logic                    ld_coef;
  logic signed [WIDTH-1:0] b_1_in;
  logic signed [WIDTH-1:0] b_0_in;
  logic                    x_valid;
  logic                    x_ready;
  logic signed [WIDTH-1:0] x_in;
  logic                    y_valid;
  logic                    y_ready;
  logic signed [WIDTH-1:0] y_out;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        sample_cnt;

  modport master (
    output ld_coef, b_1_in, b_0_in, x_valid, x_in, y_ready,
    input  x_ready, y_valid, y_out, busy, done, sample_cnt
  );

  modport slave (
    input  ld_coef, b_1_in, b_0_in, x_valid, x_in, y_ready,
    output x_ready, y_valid, y_out, busy, done, sample_cnt
  );

endinterface
`default_nettype wire

// File: rtl/regression_predictor_fxp_mac_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fxp_mac_sat                                               |
// | Purpose  : Combinational signed fixed-point multiply-accumulate with |
// |            saturation: y = sat((a*b >>> FRAC) + c).                  |
// |            The product is exposed (prod) and re-entered (prod_in) so |
// |            a pipeline can register it; tie prod to prod_in for a     |
// |            purely combinational MAC.                                 |
// | Ports    : a, b    - WIDTH-bit signed multiplicands                  |
// |            prod    - full 2*WIDTH-bit signed product a*b             |
// |            prod_in - product to scale and accumulate                 |
// |            c       - WIDTH-bit signed addend                         |
// |            y       - WIDTH-bit saturated result                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fxp_mac_sat
  import regression_predictor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] prod,
  input  logic signed [2*WIDTH-1:0] prod_in,
  input  logic signed [WIDTH-1:0]   c,
  output logic signed [WIDTH-1:0]   y
);
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] shifted;
  logic signed [2*WIDTH:0]   sum;
  logic [WIDTH+1:0]          upper;
  logic                      fits;

  assign prod    = $signed((2*WIDTH)'(a)) * $signed((2*WIDTH)'(b));
  // Arithmetic shift truncates toward negative infinity.
  assign shifted = prod_in >>> FRAC;
  assign sum     = {shifted[2*WIDTH-1], shifted} + {{(WIDTH+1){c[WIDTH-1]}}, c};

  // The sum fits in WIDTH bits only when every bit above the result's
  // sign bit is a copy of it.
  assign upper = sum[2*WIDTH:WIDTH-1];
  assign fits  = (&upper) | ~(|upper);

  always_comb begin
    y = sum[WIDTH-1:0];
    if (!fits) begin
      y = sum[2*WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regression_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regression_predictor                                      |
// | Purpose  : Latches fitted coefficients b_1/b_0 and streams x samples |
// |            through a 2-stage pipeline producing saturated            |
// |            y_hat = b_1*x + b_0, with valid/ready on both sides, a    |
// |            delivered-prediction counter and a per-set done pulse.    |
// | Ports    : clk - rising-edge clock                                   |
// |            rst - asynchronous active-low reset                       |
// |            bus - regression_predictor_if.slave (load, x/y streams,   |
// |                  busy, done, sample_cnt)                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module regression_predictor
  import regression_predictor_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FRAC        = DEF_FRAC,
  parameter int NUM_SAMPLES = 150
) (
  input  logic                        clk,
  input  logic                        rst,
  regression_predictor_if.slave       bus
);
  localparam int             CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

  logic signed [WIDTH-1:0]   coef_b1;
  logic signed [WIDTH-1:0]   coef_b0;
  logic                      coef_loaded;
  logic                      s1_valid;
  logic signed [2*WIDTH-1:0] s1_prod;
  logic                      s2_valid;
  logic signed [WIDTH-1:0]   y_q;
  logic [CNT_W-1:0]          cnt;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   mac_y;
  logic                      adv1;
  logic                      adv2;
  logic                      x_fire;
  logic                      ld_take;
  logic                      busy_w;

  assign busy_w  = s1_valid | s2_valid;
  assign adv2    = s2_valid & bus.y_ready;
  assign adv1    = s1_valid & (~s2_valid | adv2);
  // A load in progress takes priority over a sample in the same cycle.
  assign bus.x_ready = coef_loaded & ~bus.ld_coef & (~s1_valid | adv1);
  assign x_fire  = bus.x_valid & bus.x_ready;
  // Coefficients may only change with the pipeline empty.
  assign ld_take = bus.ld_coef & ~busy_w;

  assign bus.y_valid    = s2_valid;
  assign bus.y_out      = y_q;
  assign bus.busy       = busy_w;
  assign bus.sample_cnt = cnt;
  assign bus.done       = adv2 & (cnt == LAST);

  fxp_mac_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mac (
    .a       (coef_b1),
    .b       (bus.x_in),
    .prod    (prod),
    .prod_in (s1_prod),
    .c       (coef_b0),
    .y       (mac_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_b1     <= '0;
      coef_b0     <= '0;
      coef_loaded <= 1'b0;
    end else if (ld_take) begin
      coef_b1     <= bus.b_1_in;
      coef_b0     <= bus.b_0_in;
      coef_loaded <= 1'b1;
    end
  end

  // Stage 1: full-precision product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else if (x_fire) begin
      s1_valid <= 1'b1;
      s1_prod  <= prod;
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: scale, add intercept, saturate; holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      y_q      <= '0;
    end else if (adv1) begin
      s2_valid <= 1'b1;
      y_q      <= mac_y;
    end else if (adv2) begin
      s2_valid <= 1'b0;
    end
  end

  // A load needs an empty pipeline, so it never coincides with a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (ld_take) begin
      cnt <= '0;
    end else if (adv2) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/regression_predictor.md
Name: regression_predictor

Overview:
- Downstream consumer of the coefficient datapath. Latches the fitted coefficients b_1 and b_0.
- Streams x samples through a 2-stage pipeline that computes y_hat = b_1*x + b_0 in signed fixed point, with valid/ready handshakes on both sides.
- Counts delivered predictions and pulses done after a full sample set.
- Feeds the result writer and the error-reporting logic.

Parameters:
- WIDTH, 20: data width of x, coefficients and y_hat (two's complement).
- FRAC, 10: number of fractional bits (Q(WIDTH-FRAC).FRAC).
- NUM_SAMPLES, 150: predictions per set; done pulses when the last one is delivered.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- ld_coef  in  1  one-cycle pulse; latch b_1_in/b_0_in.
- b_1_in  in  WIDTH  slope coefficient from the coefficient datapath.
- b_0_in  in  WIDTH  intercept coefficient from the coefficient datapath.
- x_valid  in  1  x_in holds a valid sample.
- x_ready  out  1  block accepts x_in this cycle.
- x_in  in  WIDTH  input sample.
- y_valid  out  1  y_out holds a valid prediction.
- y_ready  in  1  downstream accepts y_out this cycle.
- y_out  out  WIDTH  saturated prediction.
- busy  out  1  one or more samples are in flight in the pipeline.
- done  out  1  one-cycle pulse on the NUM_SAMPLES-th output handshake.
- sample_cnt  out  $clog2(NUM_SAMPLES+1)  outputs delivered in the current set.

Behaviour:
- Reset (rst=0, async): all of the following clear immediately, independent of clk.
  - Coefficient registers = 0; coef_loaded = 0.
  - Both stage valids = 0; y_out = 0; y_valid = 0.
  - x_ready = 0; busy = 0; done = 0; sample_cnt = 0.
  - Reset mid-stream discards in-flight samples; no partial output appears after release.
- Coefficient load:
  - ld_coef with busy=0 latches b_1_in/b_0_in and sets coef_loaded=1 at the next edge.
  - ld_coef with busy=1 is ignored; the coefficients stay unchanged.
  - ld_coef also clears sample_cnt.
  - If ld_coef and x_valid occur in the same cycle, the load wins: x_ready is 0 that cycle.
- Input handshake:
  - x_ready = coef_loaded & !ld_coef & (!s1_valid | adv1).
  - A sample transfers on x_valid & x_ready.
- Stage 1:
  - Captures the signed product p = b_1 * x (2*WIDTH bits) and sets s1_valid.
  - adv1 = s1_valid & (!s2_valid | adv2).
- Stage 2:
  - Computes s = (p >>> FRAC) + sign-extended b_0, in 2*WIDTH+1 bits.
  - Saturates s to WIDTH bits: above max gives 2^(WIDTH-1)-1; below min gives -2^(WIDTH-1).
  - Registers the result into y_out and sets s2_valid = y_valid.
  - adv2 = s2_valid & y_ready.
- Latency and throughput:
  - Latency is 2 cycles from input handshake to y_valid.
  - Throughput is 1 sample per cycle while y_ready=1.
- Backpressure:
  - With y_ready=0, y_out and y_valid hold stable.
  - Stage 1 fills, then x_ready drops. No sample is lost or duplicated.
  - y_valid never deasserts without a handshake.
- Status:
  - busy = s1_valid | s2_valid.
  - sample_cnt increments on each y_valid & y_ready.
  - On the NUM_SAMPLES-th handshake: done=1 for one cycle, and sample_cnt wraps to 0 on the same edge.
- Rounding: truncation toward negative infinity (arithmetic shift); no rounding bias.

Decomposition:
- Shared package holds:
  - WIDTH and FRAC defaults.
  - Signed max/min saturation constants.
  - A fixed-point type (WIDTH-bit signed) for x, coefficients and y.
- One sub-module: fxp_mac_sat. Combinational; computes (a*b >>> FRAC) + c with saturation, so the error checker can reuse it.
- Pipeline registers, handshakes, counter and coefficient latch stay in the top module.

Test Plan:
- Positive values, FRAC=10:
  - Stimulus: load b_1=2048 (2.0), b_0=1024 (1.0); send x=3072 (3.0), y_ready=1.
  - Response: y_out=7168 (7.0) two cycles after accept; busy=1 in between.
- Negative values and sign extension:
  - Stimulus: b_1=0xFFE00 (-0.5), b_0=1024, x=4096 (4.0).
  - Response: y_out=0xFFC00 (-1.0).
- Saturation:
  - Stimulus: b_1=262144 (256.0), b_0=0, x=4096 gives y_out=0x7FFFF; same with x=0xFF000 (-4.0).
  - Response for x=0xFF000: y_out=0x80000.
- Backpressure:
  - Stimulus: x_valid held; y_ready=0 for 5 cycles after the first accept.
  - Response: exactly 2 samples accepted, then x_ready=0.
  - Response: after y_ready=1, outputs arrive in order with no loss or duplication.
- Count, wrap and coefficient gating:
  - Stimulus: stream 150 samples.
  - Response: done pulses once, coincident with the 150th output handshake; sample_cnt returns to 0.
  - Response: an ld_coef issued while busy=1 leaves the coefficients unchanged.
- Reset mid-stream:
  - Stimulus: rst=0 asserted asynchronously between clock edges while 2 samples are in flight.
  - Response: y_valid, busy and x_ready drop immediately; no output after release until the coefficients are reloaded.
